fifo_rptr_empty: RTL and testbench
==================================

// Module: fifo_rptr_empty
// PURPOSE
//   Read-side pointer and empty-flag generator for the dual-clock FIFO.
//   Sits directly downstream of the write-to-read pointer synchronizer and consumes its
//   2-flop-synchronized Gray write pointer. Owns the read pointer, which it exposes as:
//     - a binary RAM address, and
//     - a Gray pointer that is sent back to the read-to-write synchronizer.
//   Also produces empty, almost_empty, read fill level and a sticky underflow flag.
// PARAMETERS
//   DEPTH        8   FIFO entries. Must be a power of 2 and >= 4. AW = $clog2(DEPTH) (localparam).
//   AEMPTY_TH    2   almost_empty asserts when r_level <= AEMPTY_TH. Range 0..DEPTH-1.
// PORTS
//   r_clk       in   1     read-domain clock; all state is updated on its rising edge
//   rst         in   1     synchronous, active-high reset
//   r_en        in   1     read request from the consumer
//   rsync_ptr2  in   AW+1  Gray write pointer, already synchronized into r_clk
//   raddr       out  AW    binary read address to the FIFO RAM (= rbin[AW-1:0])
//   rptr        out  AW+1  registered Gray read pointer, sent to the write domain
//   empty       out  1     FIFO empty, registered
//   almost_empty out 1     r_level <= AEMPTY_TH, registered
//   r_level     out  AW+1  entries available as seen by the read side (0..DEPTH), registered
//   underflow   out  1     sticky: a read was attempted while empty
// BEHAVIOUR
//   - Internal state: rbin[AW:0] binary read pointer; MSB is the wrap bit.
//   - Reset (rst=1 at a r_clk edge) sets: rbin=0, rptr=0, empty=1, almost_empty=1,
//     r_level=0, underflow=0. Reset wins over r_en. A mid-operation reset discards the
//     pointer state; the write side must be reset in the same reset window.
//   - Accepted read: rd_ok = r_en & ~empty, where empty is the registered flag.
//     r_en while empty is ignored (pointer does not move) and sets underflow.
//   - Next-state values:
//       rbin_nxt  = rbin + rd_ok, modulo 2^(AW+1)
//       rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1)
//   - Each edge: rbin <= rbin_nxt; rptr <= rgray_nxt.
//     raddr therefore advances exactly 1 cycle after the accepted read.
//   - Empty: empty <= (rgray_nxt == rsync_ptr2), a full (AW+1)-bit compare including the
//     wrap bit. Empty reasserts in the same edge that consumes the last entry, so there
//     is no extra cycle of a false not-empty.
//   - Write-pointer decode: wbin_s = Gray-to-binary(rsync_ptr2), computed as a prefix
//     XOR from the MSB down.
//   - Level: r_level <= wbin_s - rbin_nxt, modulo 2^(AW+1). A legal result is 0..DEPTH.
//   - almost_empty <= (wbin_s - rbin_nxt) <= AEMPTY_TH, using the same cycle's
//     arithmetic as r_level.
//   - Consistency: empty == (r_level == 0) must hold every cycle. Add it as an assertion.
//   - Wrap-around: after 2^(AW+1) accepted reads rbin returns to 0, and the Gray pointer
//     changes exactly one bit per accepted read.
//   - Simultaneous events:
//     - A pointer change on rsync_ptr2 and an accepted read in the same cycle are both
//       reflected on the next edge.
//     - With the last entry read while a new write arrives the same cycle, empty stays 0.
//   - Latency: a write-side pointer change reaches empty/r_level 3 r_clk edges later
//     (2 synchronizer edges + 1 here). The read side may report empty conservatively;
//     it must never report not-empty falsely.
//   - underflow: set on (r_en & empty); cleared only by rst.
// TESTING
//   1. Reset: rst=1 for 2 cycles with r_en=1 ->
//      empty=1, almost_empty=1, raddr=0, rptr=4'b0000, r_level=0, underflow=0.
//   2. DEPTH=8: hold rsync_ptr2=4'b0110 (bin 4), r_en=1 for 4 cycles ->
//      raddr goes 0,1,2,3,4; rptr goes 0000,0001,0011,0010,0110;
//      r_level goes 4,3,2,1,0; empty=1 after the 4th read; almost_empty=1 from level 2.
//   3. Underflow: with empty=1, pulse r_en ->
//      rbin unchanged, underflow=1 and stays 1 until rst.
//   4. Full FIFO: rsync_ptr2=4'b1100 (bin 8), rbin=0 ->
//      r_level=8, empty=0; after 8 reads raddr=0 with wrap bit=1, rptr=4'b1100, empty=1.
//   5. Simultaneous: level=1; present r_en and rsync_ptr2 advancing by 1 in the same
//      cycle -> empty stays 0, r_level stays 1.
//   6. Long random run: 1000 cycles with a reference model of write+read ->
//      rptr is Hamming-distance <=1 between cycles; empty matches (r_level==0);
//      no read ever occurs while empty=1.

Source files
------------

// File: rtl/fifo_rptr_empty.sv
// fifo_rptr_empty: read pointer, empty/almost_empty, fill level and underflow for a dual-clock FIFO
module fifo_rptr_empty #(
  parameter int DEPTH = 8,
  parameter int AEMPTY_TH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          r_clk,
  input  logic          rst,
  input  logic          r_en,
  input  logic [AW:0]   rsync_ptr2,
  output logic [AW-1:0] raddr,
  output logic [AW:0]   rptr,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW:0]   r_level,
  output logic          underflow
);
  logic [AW:0] rbin, rbin_nxt, rgray_nxt, wbin_s, lvl_nxt;
  logic rd_ok;
  for (genvar j = 0; j <= AW; j++) begin : g_g2b
    assign wbin_s[j] = ^rsync_ptr2[AW:j];
  end
  assign rd_ok     = r_en & ~empty;
  assign rbin_nxt  = rbin + {{AW{1'b0}}, rd_ok};
  assign rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
  assign lvl_nxt   = wbin_s - rbin_nxt;
  assign raddr     = rbin[AW-1:0];
  always_ff @(posedge r_clk) begin
    if (rst) begin
      rbin         <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      r_level      <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_nxt;
      rptr         <= rgray_nxt;
      empty        <= rgray_nxt == rsync_ptr2;
      almost_empty <= lvl_nxt <= (AW+1)'(AEMPTY_TH);
      r_level      <= lvl_nxt;
      underflow    <= underflow | (r_en & empty);
    end
  end
  a_empty_level: assert property (@(posedge r_clk) disable iff (rst) empty == (r_level == '0));
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// tb_fifo_rptr_empty: scoreboard bench for the FIFO read-side pointer/empty logic
module tb_fifo_rptr_empty;
  logic r_clk = 0, rst = 1, r_en = 0;
  logic [3:0] rsync_ptr2 = '0;
  logic [2:0] raddr;
  logic [3:0] rptr, r_level;
  logic empty, almost_empty, underflow;
  typedef struct packed {
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       e;
    logic       ae;
    logic [3:0] lvl;
    logic       uf;
  } exp_t;
  exp_t q[$];
  string qn[$];
  exp_t x;
  string xn;
  int n_chk = 0, n_fail = 0;
  bit ham_on = 0;
  logic [3:0] prev_rptr = '0;
  int m_rbin, m_wcnt;
  bit m_empty, m_uf;
  logic [3:0] gt [0:8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
  fifo_rptr_empty #(.DEPTH(8), .AEMPTY_TH(2)) dut (
    .r_clk(r_clk), .rst(rst), .r_en(r_en), .rsync_ptr2(rsync_ptr2), .raddr(raddr),
    .rptr(rptr), .empty(empty), .almost_empty(almost_empty), .r_level(r_level), .underflow(underflow)
  );
  always #5 r_clk = ~r_clk;
  always @(posedge r_clk) begin
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      xn = qn.pop_front();
      n_chk++;
      if ({raddr, rptr, empty, almost_empty, r_level, underflow} != x) begin
        n_fail++;
        $display("FAIL %s: got raddr=%0d rptr=%b empty=%b ae=%b lvl=%0d uf=%b, need raddr=%0d rptr=%b empty=%b ae=%b lvl=%0d uf=%b",
                 xn, raddr, rptr, empty, almost_empty, r_level, underflow, x.raddr, x.rptr, x.e, x.ae, x.lvl, x.uf);
      end
    end
    if (ham_on) begin
      n_chk++;
      if ($countones(prev_rptr ^ rptr) > 1) begin
        n_fail++;
        $display("FAIL gray_step: rptr %b -> %b, need at most one bit change", prev_rptr, rptr);
      end
      n_chk++;
      if (empty != (r_level == 4'd0)) begin
        n_fail++;
        $display("FAIL empty_vs_level: empty=%b r_level=%0d, need empty == (r_level==0)", empty, r_level);
      end
    end
    prev_rptr = rptr;
  end
  task automatic step(input logic rs, input logic en, input logic [3:0] wp, input string nm,
                      input logic [2:0] ra, input logic [3:0] rp, input logic e, input logic ae,
                      input logic [3:0] lv, input logic uf);
    exp_t t;
    @(negedge r_clk);
    rst = rs;
    r_en = en;
    rsync_ptr2 = wp;
    t.raddr = ra;
    t.rptr = rp;
    t.e = e;
    t.ae = ae;
    t.lvl = lv;
    t.uf = uf;
    q.push_back(t);
    qn.push_back(nm);
  endtask
  task automatic mstep(input logic en, input bit wr);
    int rd, lvl;
    if (wr) m_wcnt = (m_wcnt + 1) % 16;
    rd = (en && !m_empty) ? 1 : 0;
    m_uf = m_uf | (en & m_empty);
    m_rbin = (m_rbin + rd) % 16;
    lvl = (m_wcnt - m_rbin + 16) % 16;
    m_empty = (lvl == 0);
    step(1'b0, en, 4'(m_wcnt ^ (m_wcnt >> 1)), "random", 3'(m_rbin), 4'(m_rbin ^ (m_rbin >> 1)),
         m_empty, lvl <= 2, 4'(lvl), m_uf);
  endtask
  initial begin
    step(1, 1, 4'b0000, "reset", 0, 4'b0000, 1, 1, 0, 0);
    step(1, 1, 4'b0000, "reset", 0, 4'b0000, 1, 1, 0, 0);
    step(0, 0, 4'b0110, "prefill", 0, 4'b0000, 0, 0, 4, 0);
    step(0, 1, 4'b0110, "read1", 1, 4'b0001, 0, 0, 3, 0);
    step(0, 1, 4'b0110, "read2", 2, 4'b0011, 0, 1, 2, 0);
    step(0, 1, 4'b0110, "read3", 3, 4'b0010, 0, 1, 1, 0);
    step(0, 1, 4'b0110, "read4", 4, 4'b0110, 1, 1, 0, 0);
    step(0, 1, 4'b0110, "uflow", 4, 4'b0110, 1, 1, 0, 1);
    step(0, 0, 4'b0110, "ufhold", 4, 4'b0110, 1, 1, 0, 1);
    step(0, 1, 4'b0110, "ufhold2", 4, 4'b0110, 1, 1, 0, 1);
    step(1, 0, 4'b0110, "rst2", 0, 4'b0000, 1, 1, 0, 0);
    step(0, 0, 4'b1100, "fill", 0, 4'b0000, 0, 0, 8, 0);
    for (int k = 1; k <= 8; k++)
      step(0, 1, 4'b1100, "full", 3'(k), gt[k], k == 8, (8 - k) <= 2, 4'(8 - k), 0);
    step(0, 0, 4'b1101, "simul0", 0, 4'b1100, 0, 1, 1, 0);
    step(0, 1, 4'b1111, "simul1", 1, 4'b1101, 0, 1, 1, 0);
    step(0, 1, 4'b1110, "simul2", 2, 4'b1111, 0, 1, 1, 0);
    step(0, 1, 4'b1110, "simul3", 3, 4'b1110, 1, 1, 0, 0);
    m_rbin = 11;
    m_wcnt = 11;
    m_empty = 1;
    m_uf = 0;
    @(negedge r_clk);
    ham_on = 1;
    for (int i = 0; i < 1000; i++)
      mstep($urandom_range(0, 3) != 0, ((m_wcnt - m_rbin + 16) % 16 < 8) && ($urandom_range(0, 1) == 1));
    @(negedge r_clk);
    @(negedge r_clk);
    ham_on = 0;
    @(negedge r_clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
